// File: rtl/alu_serial_seq.sv
// alu_serial_seq: LSB-first bit-serial ALU sequencer feeding an external logic/arith extender slice.
// Optional Z/N/V flags built only when ALU_FLAGS_EN is defined; latency WIDTH+1 cycles, start ignored while busy.
module alu_serial_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ai,
   output logic             bi,
   output logic             s0,
   output logic             s1,
   output logic             M,
   input  logic             xi,
   input  logic             yi,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_v
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_result;
   logic             r_cout;
   logic             r_M;
   logic             r_s1;
   logic             r_s0;

   logic             w_run;
   logic             w_last;
   logic             w_bit;
   logic             w_carry_nxt;
   logic [WIDTH-1:0] w_res_nxt;

   assign w_run       = (r_state == S_RUN);
   assign w_last      = (r_cnt == CW'(WIDTH - 1));
   assign w_bit       = xi ^ yi ^ (r_carry & r_M);
   assign w_carry_nxt = r_M & ((xi & yi) | (xi & r_carry) | (yi & r_carry));
   // Result bits fill the vacated top of the A shifter, so after WIDTH shifts it holds the whole result.
   assign w_res_nxt   = {w_bit, r_a_sh[WIDTH-1:1]};

   assign ai     = w_run & r_a_sh[0];
   assign bi     = w_run & r_b_sh[0];
   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;
   assign cout   = r_cout;
   assign M      = r_M;
   assign s1     = r_s1;
   assign s0     = r_s0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_M      <= 1'b0;
         r_s1     <= 1'b0;
         r_s0     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_a_sh  <= a_in;
                  r_b_sh  <= b_in;
                  r_M     <= op[2];
                  r_s1    <= op[1];
                  r_s0    <= op[0];
                  r_carry <= op[2] & (op[1] ^ op[0]);
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_a_sh  <= w_res_nxt;
               r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
               r_carry <= w_carry_nxt;
               r_cnt   <= r_cnt + CW'(1);
               if (w_last) begin
                  r_result <= w_res_nxt;
                  r_cout   <= w_carry_nxt;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef ALU_FLAGS_EN
   logic r_flag_z;
   logic r_flag_n;
   logic r_flag_v;
   logic w_c_msb;

   // While the MSB is being formed, the live carry is the carry into the MSB.
   assign w_c_msb = r_carry;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flag_z <= 1'b0;
         r_flag_n <= 1'b0;
         r_flag_v <= 1'b0;
      end else if (w_run && w_last) begin
         r_flag_z <= (w_res_nxt == '0);
         r_flag_n <= w_res_nxt[WIDTH-1];
         r_flag_v <= r_M & (w_c_msb ^ w_carry_nxt);
      end
   end

   assign flag_z = r_flag_z;
   assign flag_n = r_flag_n;
   assign flag_v = r_flag_v;
`else
   assign flag_z = 1'b0;
   assign flag_n = 1'b0;
   assign flag_v = 1'b0;
`endif

endmodule
